// File: rtl/crc_pkg.sv
// Shared definitions for the CRC offload block: transfer-length codes, scheduler
// state encoding and the AHB encodings reused by the master and slave.
package crc_pkg;

    typedef enum logic [1:0] {
        SingleData  = 2'b00,
        OneRow      = 2'b01,
        Brst2Row    = 2'b10,
        DlenIllegal = 2'b11
    } dlen_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP_RD = 3'd1,
        S_WAIT_RD  = 3'd2,
        S_CRC      = 3'd3,
        S_SETUP_WR = 3'd4,
        S_WAIT_WR  = 3'd5
    } sched_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    function automatic logic dlen_legal(input logic [1:0] dlen);
        return (dlen != DlenIllegal);
    endfunction

endpackage

// File: rtl/crc_job_scheduler_if.sv
// Job request and master/CRC-engine sequencing signals of the CRC job scheduler.
interface crc_job_scheduler_if #(parameter int ADDR_WIDTH = 16);
    logic                  job_valid;
    logic                  job_ready;
    logic [ADDR_WIDTH-1:0] job_dadr;
    logic [ADDR_WIDTH-1:0] job_cadr;
    logic [1:0]            job_dlen;
    logic [ADDR_WIDTH-1:0] mst_dadr;
    logic [ADDR_WIDTH-1:0] mst_cadr;
    logic [1:0]            mst_dlen;
    logic                  mst_regs_ready;
    logic                  mst_write;
    logic                  mst_done;
    logic                  crc_start;
    logic                  crc_done;

    modport slave (
        input  job_valid, job_dadr, job_cadr, job_dlen, mst_done, crc_done,
        output job_ready, mst_dadr, mst_cadr, mst_dlen, mst_regs_ready, mst_write, crc_start
    );

    modport master (
        output job_valid, job_dadr, job_cadr, job_dlen, mst_done, crc_done,
        input  job_ready, mst_dadr, mst_cadr, mst_dlen, mst_regs_ready, mst_write, crc_start
    );
endinterface

// File: rtl/crc_job_fifo.sv
// Synchronous job FIFO with show-ahead read data; a pop never frees space for a
// push in the same cycle because push is gated by the registered full flag.
module crc_job_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Read/write pointers with wrap bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_q + {{AW{1'b0}}, do_push_s};
            rptr_q <= rptr_q + {{AW{1'b0}}, do_pop_s};
        end
    end
endmodule

// File: rtl/crc_job_scheduler.sv
// Buffers CRC jobs and walks the AHB master and CRC engine through read, checksum
// and write-back phases, one job at a time, with a per-phase watchdog.
module crc_job_scheduler
    import crc_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int QDEPTH     = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                HCLK,
    input  logic                RESET,
    crc_job_scheduler_if.slave  bus,
    input  logic                err_clr,
    output logic                busy,
    output logic [7:0]          jobs_done,
    output logic                timeout_err,
    output logic                dlen_err
);
    localparam int         JW       = 2 * ADDR_WIDTH + 2;
    localparam logic [7:0] TO_LIMIT = TIMEOUT[7:0];

    sched_state_e          state_q, state_d;
    logic [7:0]            wd_q, wd_d;
    logic [7:0]            jobs_q, jobs_d;
    logic                  to_err_q, to_err_d;
    logic                  dl_err_q, dl_err_d;
    logic [ADDR_WIDTH-1:0] dadr_q, dadr_d;
    logic [ADDR_WIDTH-1:0] cadr_q, cadr_d;
    logic [1:0]            dlen_q, dlen_d;
    logic                  regs_rdy_q, regs_rdy_d;
    logic                  crc_start_q, crc_start_d;
    logic                  write_q, write_d;

    logic [JW-1:0]         fifo_wdata_s, fifo_rdata_s;
    logic                  fifo_full_s, fifo_empty_s, pop_s;
    logic [ADDR_WIDTH-1:0] head_dadr_s, head_cadr_s;
    logic [1:0]            head_dlen_s;

    assign fifo_wdata_s = {bus.job_dadr, bus.job_cadr, bus.job_dlen};
    assign head_dadr_s  = fifo_rdata_s[JW-1:ADDR_WIDTH+2];
    assign head_cadr_s  = fifo_rdata_s[ADDR_WIDTH+1:2];
    assign head_dlen_s  = fifo_rdata_s[1:0];

    crc_job_fifo #(.WIDTH(JW), .DEPTH(QDEPTH)) u_fifo (
        .clk     (HCLK),
        .rst_n   (RESET),
        .push_i  (bus.job_valid),
        .pop_i   (pop_s),
        .wdata_i (fifo_wdata_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // job_ready is held low while the block is in reset
    assign bus.job_ready      = RESET & ~fifo_full_s;
    assign bus.mst_dadr       = dadr_q;
    assign bus.mst_cadr       = cadr_q;
    assign bus.mst_dlen       = dlen_q;
    assign bus.mst_regs_ready = regs_rdy_q;
    assign bus.mst_write      = write_q;
    assign bus.crc_start      = crc_start_q;
    assign busy               = (state_q != S_IDLE) | ~fifo_empty_s;
    assign jobs_done          = jobs_q;
    assign timeout_err        = to_err_q;
    assign dlen_err           = dl_err_q;

    // Scheduler state and all registered outputs
    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            wd_q        <= 8'd0;
            jobs_q      <= 8'd0;
            to_err_q    <= 1'b0;
            dl_err_q    <= 1'b0;
            dadr_q      <= '0;
            cadr_q      <= '0;
            dlen_q      <= 2'b00;
            regs_rdy_q  <= 1'b0;
            crc_start_q <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            jobs_q      <= jobs_d;
            to_err_q    <= to_err_d;
            dl_err_q    <= dl_err_d;
            dadr_q      <= dadr_d;
            cadr_q      <= cadr_d;
            dlen_q      <= dlen_d;
            regs_rdy_q  <= regs_rdy_d;
            crc_start_q <= crc_start_d;
            write_q     <= write_d;
        end
    end

    // Next-state, watchdog and error logic; error set is applied after clear so set wins
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        jobs_d      = jobs_q;
        to_err_d    = to_err_q & ~err_clr;
        dl_err_d    = dl_err_q & ~err_clr;
        dadr_d      = dadr_q;
        cadr_d      = cadr_q;
        dlen_d      = dlen_q;
        regs_rdy_d  = 1'b0;
        crc_start_d = 1'b0;
        write_d     = write_q;
        pop_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                write_d = 1'b0;
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (dlen_legal(head_dlen_s)) begin
                        dadr_d  = head_dadr_s;
                        cadr_d  = head_cadr_s;
                        dlen_d  = head_dlen_s;
                        state_d = S_SETUP_RD;
                    end else begin
                        dl_err_d = 1'b1;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            S_SETUP_RD: begin
                write_d    = 1'b0;
                wd_d       = 8'd0;
                regs_rdy_d = 1'b1;
                state_d    = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (bus.mst_done) begin
                    wd_d        = 8'd0;
                    crc_start_d = 1'b1;
                    state_d     = S_CRC;
                end else if (wd_q == TO_LIMIT) begin
                    to_err_d = 1'b1;
                    write_d  = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_CRC: begin
                if (bus.crc_done) begin
                    write_d = 1'b1;
                    state_d = S_SETUP_WR;
                end else if (wd_q == TO_LIMIT) begin
                    to_err_d = 1'b1;
                    write_d  = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_SETUP_WR: begin
                write_d    = 1'b1;
                wd_d       = 8'd0;
                regs_rdy_d = 1'b1;
                state_d    = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (bus.mst_done) begin
                    jobs_d  = jobs_q + 8'd1;
                    write_d = 1'b0;
                    state_d = S_IDLE;
                end else if (wd_q == TO_LIMIT) begin
                    to_err_d = 1'b1;
                    write_d  = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: begin
                write_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_crc_job_scheduler.sv
// Directed self-checking bench for crc_job_scheduler: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_crc_job_scheduler;
    logic       HCLK;
    logic       RESET;
    logic       err_clr;
    logic       busy;
    logic [7:0] jobs_done;
    logic       timeout_err;
    logic       dlen_err;
    int         n_cmp;
    int         n_bad;

    crc_job_scheduler_if #(.ADDR_WIDTH(16)) bus ();

    crc_job_scheduler #(.ADDR_WIDTH(16), .QDEPTH(4), .TIMEOUT(255)) dut (
        .HCLK        (HCLK),
        .RESET       (RESET),
        .bus         (bus),
        .err_clr     (err_clr),
        .busy        (busy),
        .jobs_done   (jobs_done),
        .timeout_err (timeout_err),
        .dlen_err    (dlen_err)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Present one job and hold it until accepted; returns at the negedge after the accepting posedge
    task automatic push_job(input logic [15:0] d, input logic [15:0] c, input logic [1:0] l, output bit ok);
        bus.job_valid = 1'b1; bus.job_dadr = d; bus.job_cadr = c; bus.job_dlen = l;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.job_ready) begin
                ok = 1'b1;
                @(negedge HCLK);
                break;
            end
            @(negedge HCLK);
        end
        bus.job_valid = 1'b0;
    endtask

    // Plays master and CRC engine for one job, capturing the config seen at each regs_ready
    task automatic serve_job(input int rd_dly, input int crc_dly, input int wr_dly,
                             output logic [15:0] d, output logic [15:0] c, output logic [1:0] l,
                             output logic w0, output logic w1, output bit ok);
        bit got;
        ok = 1'b1; d = '0; c = '0; l = 2'b00; w0 = 1'b1; w1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.mst_regs_ready) begin got = 1'b1; break; end
            @(negedge HCLK);
        end
        if (!got) begin ok = 1'b0; return; end
        d = bus.mst_dadr; c = bus.mst_cadr; l = bus.mst_dlen; w0 = bus.mst_write;
        repeat (rd_dly - 1) @(negedge HCLK);
        bus.mst_done = 1'b1; @(negedge HCLK); bus.mst_done = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.crc_start) begin got = 1'b1; break; end
            @(negedge HCLK);
        end
        if (!got) begin ok = 1'b0; return; end
        repeat (crc_dly - 1) @(negedge HCLK);
        bus.crc_done = 1'b1; @(negedge HCLK); bus.crc_done = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.mst_regs_ready) begin got = 1'b1; break; end
            @(negedge HCLK);
        end
        if (!got) begin ok = 1'b0; return; end
        w1 = bus.mst_write;
        repeat (wr_dly - 1) @(negedge HCLK);
        bus.mst_done = 1'b1; @(negedge HCLK); bus.mst_done = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; err_clr = 1'b0;
        bus.job_valid = 1'b0; bus.job_dadr = '0; bus.job_cadr = '0; bus.job_dlen = 2'b00;
        bus.mst_done = 1'b0; bus.crc_done = 1'b0;
        #2 RESET = 1'b0;
        repeat (3) @(negedge HCLK);
        n_cmp++; if (bus.job_ready !== 1'b0) begin n_bad++; $display("FAIL rst_job_ready: got %b want 0", bus.job_ready); end
        n_cmp++; if (bus.mst_regs_ready !== 1'b0 || bus.crc_start !== 1'b0 || bus.mst_write !== 1'b0) begin
            n_bad++; $display("FAIL rst_pulses: got rr=%b cs=%b wr=%b want 0", bus.mst_regs_ready, bus.crc_start, bus.mst_write); end
        n_cmp++; if (busy !== 1'b0 || jobs_done !== 8'd0 || timeout_err !== 1'b0 || dlen_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_status: got busy=%b jobs=%0d to=%b dl=%b want 0", busy, jobs_done, timeout_err, dlen_err); end
        n_cmp++; if (bus.mst_dadr !== 16'h0000 || bus.mst_cadr !== 16'h0000 || bus.mst_dlen !== 2'b00) begin
            n_bad++; $display("FAIL rst_mst_cfg: got %h %h %b want 0", bus.mst_dadr, bus.mst_cadr, bus.mst_dlen); end
        RESET = 1'b1;
        #1;
        n_cmp++; if (bus.job_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.job_ready); end
        @(negedge HCLK);
    endtask

    task automatic test_single_job();
        bit ok; logic [15:0] d, c; logic [1:0] l; logic w0, w1;
        push_job(16'h0010, 16'h0100, 2'b01, ok);
        n_cmp++; if (ok !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL single_push: got ok=%b busy=%b want 1 1", ok, busy); end
        @(negedge HCLK);
        n_cmp++; if (bus.mst_regs_ready !== 1'b0 || bus.mst_dadr !== 16'h0010) begin
            n_bad++; $display("FAIL single_pop_edge: got rr=%b dadr=%h want 0 0010", bus.mst_regs_ready, bus.mst_dadr); end
        @(negedge HCLK);
        n_cmp++; if (bus.mst_regs_ready !== 1'b1) begin n_bad++; $display("FAIL single_latency: got rr=%b want 1", bus.mst_regs_ready); end
        serve_job(6, 3, 2, d, c, l, w0, w1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_handshake: got %b want 1", ok); end
        n_cmp++; if (d !== 16'h0010 || c !== 16'h0100 || l !== 2'b01) begin
            n_bad++; $display("FAIL single_cfg: got %h %h %b want 0010 0100 01", d, c, l); end
        n_cmp++; if (w0 !== 1'b0 || w1 !== 1'b1) begin n_bad++; $display("FAIL single_write_phase: got %b%b want 01", w0, w1); end
        n_cmp++; if (jobs_done !== 8'd1 || busy !== 1'b0 || bus.mst_write !== 1'b0) begin
            n_bad++; $display("FAIL single_end: got jobs=%0d busy=%b wr=%b want 1 0 0", jobs_done, busy, bus.mst_write); end
        n_cmp++; if (bus.mst_dadr !== 16'h0010) begin n_bad++; $display("FAIL single_hold_cfg: got %h want 0010", bus.mst_dadr); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got_d [6];
        logic [15:0] got_c [6];
        bit          got_ok [6];
        fork
            begin
                bit pok;
                for (int j = 0; j < 5; j++) begin
                    push_job(16'h1000 + 16'(j), 16'h2000 + 16'(j), 2'(j % 3), pok);
                end
                n_cmp++; if (bus.job_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got ready=%b want 0", bus.job_ready); end
                push_job(16'h1005, 16'h2005, 2'b10, pok);
                n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL b2b_held_push: got %b want 1", pok); end
            end
            begin
                logic [15:0] d, c; logic [1:0] l; logic w0, w1; bit ok;
                for (int j = 0; j < 6; j++) begin
                    serve_job(6, 3, 2, d, c, l, w0, w1, ok);
                    got_d[j] = d; got_c[j] = c; got_ok[j] = ok;
                end
            end
        join
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (got_ok[j] !== 1'b1 || got_d[j] !== 16'h1000 + 16'(j) || got_c[j] !== 16'h2000 + 16'(j)) begin
                n_bad++; $display("FAIL b2b_order[%0d]: got ok=%b %h %h want 1 %h %h", j, got_ok[j], got_d[j], got_c[j],
                                  16'h1000 + 16'(j), 16'h2000 + 16'(j));
            end
        end
        n_cmp++; if (jobs_done !== 8'd7 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_count: got %0d busy=%b want 7 0", jobs_done, busy); end
    endtask

    task automatic test_dlen_err();
        bit ok; logic [15:0] d, c; logic [1:0] l; logic w0, w1;
        push_job(16'hBAD0, 16'hBAD1, 2'b11, ok);
        push_job(16'h0300, 16'h0301, 2'b00, ok);
        serve_job(2, 2, 2, d, c, l, w0, w1, ok);
        n_cmp++; if (dlen_err !== 1'b1) begin n_bad++; $display("FAIL dlen_err_set: got %b want 1", dlen_err); end
        n_cmp++; if (ok !== 1'b1 || d !== 16'h0300 || l !== 2'b00) begin
            n_bad++; $display("FAIL dlen_skip: got ok=%b dadr=%h dlen=%b want 1 0300 00", ok, d, l); end
        n_cmp++; if (jobs_done !== 8'd8) begin n_bad++; $display("FAIL dlen_count: got %0d want 8", jobs_done); end
        err_clr = 1'b1; @(negedge HCLK); err_clr = 1'b0;
        n_cmp++; if (dlen_err !== 1'b0) begin n_bad++; $display("FAIL dlen_clr: got %b want 0", dlen_err); end
    endtask

    task automatic test_crc_timeout();
        bit ok; bit got;
        push_job(16'h0400, 16'h0401, 2'b01, ok);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mst_regs_ready) begin got = 1'b1; break; end
            @(negedge HCLK);
        end
        bus.mst_done = 1'b1; @(negedge HCLK); bus.mst_done = 1'b0;
        n_cmp++; if (got !== 1'b1 || bus.crc_start !== 1'b1) begin
            n_bad++; $display("FAIL to_enter_crc: got rr=%b cs=%b want 1 1", got, bus.crc_start); end
        repeat (255) @(negedge HCLK);
        n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL to_early: got to=%b busy=%b want 0 1", timeout_err, busy); end
        err_clr = 1'b1; @(negedge HCLK); err_clr = 1'b0;
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_set_wins: got %b want 1", timeout_err); end
        n_cmp++; if (busy !== 1'b0 || jobs_done !== 8'd8 || bus.mst_write !== 1'b0) begin
            n_bad++; $display("FAIL to_abort: got busy=%b jobs=%0d wr=%b want 0 8 0", busy, jobs_done, bus.mst_write); end
        err_clr = 1'b1; @(negedge HCLK); err_clr = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_clr: got %b want 0", timeout_err); end
    endtask

    task automatic test_exact_timeout();
        bit ok; bit got;
        bus.mst_done = 1'b1; bus.crc_done = 1'b1; @(negedge HCLK);
        bus.mst_done = 1'b0; bus.crc_done = 1'b0; @(negedge HCLK);
        n_cmp++; if (jobs_done !== 8'd8 || busy !== 1'b0 || bus.crc_start !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignore: got jobs=%0d busy=%b cs=%b want 8 0 0", jobs_done, busy, bus.crc_start); end
        push_job(16'h0500, 16'h0501, 2'b10, ok);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mst_regs_ready) begin got = 1'b1; break; end
            @(negedge HCLK);
        end
        repeat (255) @(negedge HCLK);
        bus.mst_done = 1'b1; @(negedge HCLK); bus.mst_done = 1'b0;
        n_cmp++; if (got !== 1'b1 || bus.crc_start !== 1'b1 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL exact_to_win: got rr=%b cs=%b to=%b want 1 1 0", got, bus.crc_start, timeout_err); end
        @(negedge HCLK);
        bus.crc_done = 1'b1; @(negedge HCLK); bus.crc_done = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mst_regs_ready) begin got = 1'b1; break; end
            @(negedge HCLK);
        end
        n_cmp++; if (got !== 1'b1 || bus.mst_write !== 1'b1) begin
            n_bad++; $display("FAIL exact_wr_phase: got rr=%b wr=%b want 1 1", got, bus.mst_write); end
        bus.mst_done = 1'b1; @(negedge HCLK); bus.mst_done = 1'b0;
        n_cmp++; if (jobs_done !== 8'd9 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL exact_done: got jobs=%0d to=%b want 9 0", jobs_done, timeout_err); end
    endtask

    task automatic test_reset_mid_job();
        bit ok; bit got; int pulses;
        push_job(16'h0600, 16'h0601, 2'b01, ok);
        push_job(16'h0700, 16'h0701, 2'b01, ok);
        push_job(16'h0800, 16'h0801, 2'b01, ok);
        for (int i = 0; i < 50; i++) begin
            if (bus.mst_regs_ready) break;
            @(negedge HCLK);
        end
        bus.mst_done = 1'b1; @(negedge HCLK); bus.mst_done = 1'b0;
        bus.crc_done = 1'b1; @(negedge HCLK); bus.crc_done = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mst_regs_ready) begin got = 1'b1; break; end
            @(negedge HCLK);
        end
        n_cmp++; if (got !== 1'b1 || bus.mst_write !== 1'b1) begin
            n_bad++; $display("FAIL mid_reach_wr: got rr=%b wr=%b want 1 1", got, bus.mst_write); end
        RESET = 1'b0;
        #1;
        n_cmp++; if (bus.mst_regs_ready !== 1'b0 || bus.mst_write !== 1'b0 || busy !== 1'b0 || bus.job_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_out: got rr=%b wr=%b busy=%b rdy=%b want 0 0 0 0",
                              bus.mst_regs_ready, bus.mst_write, busy, bus.job_ready); end
        n_cmp++; if (jobs_done !== 8'd0 || bus.mst_dadr !== 16'h0000) begin
            n_bad++; $display("FAIL mid_rst_regs: got jobs=%0d dadr=%h want 0 0000", jobs_done, bus.mst_dadr); end
        @(negedge HCLK);
        RESET = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (bus.mst_regs_ready || bus.crc_start || busy) pulses++;
        end
        n_cmp++; if (pulses !== 0 || bus.job_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_after: got activity=%0d rdy=%b want 0 1", pulses, bus.job_ready); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_dlen_err();
        test_crc_timeout();
        test_exact_timeout();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
